// File: rtl/cache_types_pkg.sv
// Shared cacheline/burst geometry and the adapter's state encoding.
// A 256-bit line moves as four 64-bit beats; lines are 32-byte aligned.
package cache_types_pkg;

  localparam int LINE_W      = 256;
  localparam int BEAT_W      = 64;
  localparam int BEATS       = 4;
  localparam int OFFSET_BITS = 5;

  localparam logic [31:0] LINE_ADDR_MASK = ~32'((1 << OFFSET_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Converts single-cycle cacheline fill/write-back requests from the cache
// into four-beat 64-bit bursts toward memory, and back.
//
// state | meaning
// IDLE  | waiting for read_i/write_i (write wins when both are high)
// READ  | collecting four memory beats into line_o
// WRITE | presenting four buffered beats on burst_o
// DONE  | one-cycle resp_o pulse, then back to IDLE
module cacheline_burst_adapter
  import cache_types_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [LINE_W-1:0]   line_i,
  output logic [LINE_W-1:0]   line_o,
  input  logic [31:0]         address_i,
  input  logic                read_i,
  input  logic                write_i,
  output logic                resp_o,
  input  logic [BEAT_W-1:0]   burst_i,
  output logic [BEAT_W-1:0]   burst_o,
  output logic [31:0]         address_o,
  output logic                read_o,
  output logic                write_o,
  input  logic                resp_i
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  state_t            state;
  logic [1:0]        beat;
  logic [LINE_W-1:0] wr_buf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      line_o    <= '0;
      address_o <= '0;
      wr_buf    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            state     <= write_i ? WRITE : READ;
            address_o <= address_i & LINE_ADDR_MASK;
            wr_buf    <= line_i;
            beat      <= '0;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[{beat, 6'd0} +: BEAT_W] <= burst_i;
            beat <= beat + 2'd1;
            if (beat == LAST_BEAT) state <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) begin
            beat <= beat + 2'd1;
            if (beat == LAST_BEAT) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request strobes and the write beat are decoded straight from state so
  // memory sees them in the same cycle the burst phase begins.
  assign read_o  = (state == READ);
  assign write_o = (state == WRITE);
  assign resp_o  = (state == DONE);
  assign burst_o = (state == WRITE) ? wr_buf[{beat, 6'd0} +: BEAT_W] : '0;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
module tb_cacheline_burst_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int tests  = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  cacheline_burst_adapter dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: what phase the link is in, how many beats of
  // the current burst have been exchanged, and the words seen so far.
  typedef enum int {M_IDLE, M_FILL, M_EVICT, M_ACK} phase_t;
  phase_t      m_phase = M_IDLE;
  int          m_beats = 0;
  logic [63:0] m_line [4] = '{default: '0};
  logic [63:0] m_wbuf [4] = '{default: '0};
  logic [31:0] m_addr = '0;
  int          m_acks = 0;

  function automatic logic [255:0] m_line_flat();
    return {m_line[3], m_line[2], m_line[1], m_line[0]};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = M_IDLE;
      m_beats = 0;
      m_addr  = '0;
      for (int j = 0; j < 4; j++) begin
        m_line[j] = '0;
        m_wbuf[j] = '0;
      end
    end else begin
      case (m_phase)
        M_IDLE: if (read_i || write_i) begin
          m_phase = write_i ? M_EVICT : M_FILL;
          m_addr  = address_i - (address_i % 32);
          for (int j = 0; j < 4; j++) m_wbuf[j] = line_i[64*j +: 64];
          m_beats = 0;
        end
        M_FILL: if (resp_i) begin
          m_line[m_beats] = burst_i;
          m_beats++;
          if (m_beats == 4) begin m_phase = M_ACK; m_beats = 0; end
        end
        M_EVICT: if (resp_i) begin
          m_beats++;
          if (m_beats == 4) begin m_phase = M_ACK; m_beats = 0; end
        end
        M_ACK: begin
          m_phase = M_IDLE;
          m_acks++;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_read_o",  256'(read_o),  256'(m_phase == M_FILL));
      check("model_write_o", 256'(write_o), 256'(m_phase == M_EVICT));
      check("model_resp_o",  256'(resp_o),  256'(m_phase == M_ACK));
      check("model_address_o", 256'(address_o), 256'(m_addr));
      check("model_line_o", line_o, m_line_flat());
      check("model_burst_o", 256'(burst_o),
            256'((m_phase == M_EVICT) ? m_wbuf[m_beats] : 64'h0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    read_i = 0; write_i = 0; resp_i = 0; burst_i = '0;
  endtask

  localparam logic [63:0] BA = 64'hAAAA_0000_AAAA_0001;
  localparam logic [63:0] BB = 64'hBBBB_0000_BBBB_0002;
  localparam logic [63:0] BC = 64'hCCCC_0000_CCCC_0003;
  localparam logic [63:0] BD = 64'hDDDD_0000_DDDD_0004;
  localparam logic [63:0] W0 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] W1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] W2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] W3 = 64'h9999_AAAA_BBBB_CCCD;

  initial begin
    logic [63:0] beats [4];
    logic [63:0] wr    [4];
    bit          pat   [7];
    int          k;
    int          resp_cnt;

    rst = 1; line_i = '0; address_i = '0; idle_inputs();
    tick(); tick();
    rst = 0;
    chk_en = 1;
    check("reset_line_o", line_o, 256'h0);
    check("reset_address_o", 256'(address_o), 256'h0);
    check("reset_strobes", 256'({read_o, write_o, resp_o}), 256'h0);
    check("reset_burst_o", 256'(burst_o), 256'h0);

    // Back-to-back read: beats on cycles 1-4, resp_o on cycle 5.
    read_i = 1; address_i = 32'h0000_1234;
    beats[0] = BA; beats[1] = BB; beats[2] = BC; beats[3] = BD;
    tick();
    read_i = 0;
    for (int i = 0; i < 4; i++) begin
      check("rd_read_o", 256'(read_o), 256'h1);
      resp_i = 1; burst_i = beats[i];
      tick();
    end
    idle_inputs();
    check("rd_resp_cycle5", 256'(resp_o), 256'h1);
    check("rd_address_o", 256'(address_o), 256'h0000_1220);
    check("rd_line_o", line_o, {BD, BC, BB, BA});
    check("model_pin_line", m_line_flat(), {BD, BC, BB, BA});
    check("model_pin_addr", 256'(m_addr), 256'h0000_1220);
    tick();
    check("rd_resp_one_cycle", 256'(resp_o), 256'h0);

    // Stray memory strobe in IDLE must not touch line_o.
    resp_i = 1; burst_i = '1;
    tick(); tick();
    check("stray_line_o", line_o, {BD, BC, BB, BA});
    check("stray_resp_o", 256'(resp_o), 256'h0);
    idle_inputs();

    // Write-back of four distinct words.
    wr[0] = W0; wr[1] = W1; wr[2] = W2; wr[3] = W3;
    line_i = {W3, W2, W1, W0}; address_i = 32'hCAFE_F00D; write_i = 1;
    tick();
    write_i = 0; line_i = '0;
    for (int i = 0; i < 4; i++) begin
      check("wr_write_o", 256'(write_o), 256'h1);
      check("wr_burst_word", 256'(burst_o), 256'(wr[i]));
      resp_i = 1;
      tick();
    end
    resp_i = 0;
    check("wr_resp_o", 256'(resp_o), 256'h1);
    check("wr_burst_zero_done", 256'(burst_o), 256'h0);
    check("wr_address_o", 256'(address_o), 256'hCAFE_F000);
    tick();

    // Stalled read with resp_i pattern 1,0,0,1,0,1,1.
    pat = '{1, 0, 0, 1, 0, 1, 1};
    read_i = 1; address_i = 32'h0000_0040;
    tick();
    read_i = 0;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      resp_i = pat[i];
      burst_i = 64'h5000 + 64'(i);
      if (pat[i]) beats[k++] = burst_i;
      tick();
      if (i < 6) check("stall_no_early_resp", 256'(resp_o), 256'h0);
    end
    idle_inputs();
    check("stall_resp_o", 256'(resp_o), 256'h1);
    check("stall_line_o", line_o, {64'h5006, 64'h5005, 64'h5003, 64'h5000});
    check("stall_capture_count", 256'(k), 256'd4);
    tick();

    // read_i and write_i together: write wins.
    read_i = 1; write_i = 1; line_i = {W0, W1, W2, W3};
    tick();
    check("both_write_o", 256'(write_o), 256'h1);
    check("both_read_o", 256'(read_o), 256'h0);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin resp_i = 1; tick(); end
    resp_i = 0;
    check("both_resp_o", 256'(resp_o), 256'h1);
    tick();

    // Reset after two write beats aborts with no response.
    write_i = 1; line_i = {W3, W2, W1, W0};
    tick();
    write_i = 0;
    resp_i = 1; tick(); tick();
    resp_i = 0; rst = 1;
    tick();
    rst = 0;
    check("abort_write_o", 256'(write_o), 256'h0);
    check("abort_resp_o", 256'(resp_o), 256'h0);
    check("abort_line_o", line_o, 256'h0);
    resp_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_o) resp_cnt++;
      tick();
    end
    check("abort_no_resp", 256'(resp_cnt), 256'h0);
    read_i = 1; address_i = 32'h8000_003F;
    tick();
    read_i = 0;
    for (int i = 0; i < 4; i++) begin resp_i = 1; burst_i = wr[i]; tick(); end
    idle_inputs();
    check("post_abort_resp_o", 256'(resp_o), 256'h1);
    check("post_abort_line_o", line_o, {W3, W2, W1, W0});
    check("post_abort_addr", 256'(address_o), 256'h8000_0020);
    tick();

    // Request held high through DONE restarts right after IDLE.
    read_i = 1; address_i = 32'h0000_0100;
    tick();
    for (int i = 0; i < 4; i++) begin resp_i = 1; burst_i = 64'(i); tick(); end
    resp_i = 0;
    check("held_resp_o", 256'(resp_o), 256'h1);
    tick();
    check("held_idle_gap", 256'(read_o), 256'h0);
    tick();
    check("held_restart", 256'(read_o), 256'h1);
    read_i = 0;
    for (int i = 0; i < 4; i++) begin resp_i = 1; tick(); end
    idle_inputs();
    tick();

    // Randomized traffic, checked every cycle by the model compare.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 199) == 0);
      read_i    = ($urandom_range(0, 2) == 0);
      write_i   = ($urandom_range(0, 3) == 0);
      resp_i    = $urandom_range(0, 1) == 1;
      burst_i   = {$urandom, $urandom};
      address_i = $urandom;
      line_i    = {$urandom, $urandom, $urandom, $urandom,
                   $urandom, $urandom, $urandom, $urandom};
      tick();
    end
    rst = 0; idle_inputs();
    tick();
    check("random_acks_seen", 256'(m_acks > 20), 256'h1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
